// File: rtl/step_controller.sv
// Debounced single-step / CPU-reset controller with optional auto-run stepping.
// Optional feature macro: STEP_CONTROLLER_AUTORUN_EN (auto-run period stepper).
module step_controller #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RUN_PERIOD      = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        step_button,
    input  logic        reset_button,
    input  logic        run_switch,
    output logic        step_pulse,
    output logic        cpu_reset,
    output logic [15:0] step_count,
    output logic        running
);

    typedef enum logic [1:0] {IDLE, ARM_PRESS, HELD, ARM_RELEASE} db_state_t;

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef STEP_CONTROLLER_AUTORUN_EN
    localparam int NSYNC = 3;
    logic [NSYNC-1:0] raw_in;
    assign raw_in = {run_switch, reset_button, step_button};
`else
    localparam int NSYNC = 2;
    logic [NSYNC-1:0] raw_in;
    logic             unused_run_switch;
    assign raw_in            = {reset_button, step_button};
    assign unused_run_switch = run_switch;
`endif

    logic [NSYNC-1:0] sync1_reg, sync2_reg;
    logic [1:0]       press_evt;
    logic [1:0]       btn_active;
    logic [1:0]       rst_hold_reg;
    logic             pulse_reg;
    logic [15:0]      step_count_reg;
    logic             manual_evt;
    logic             auto_evt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Index 0 debounces the step button, index 1 the CPU-reset button.
    for (genvar gi = 0; gi < 2; gi++) begin : g_db
        db_state_t     state_reg, state_next;
        logic [CW-1:0] cnt_reg, cnt_next;
        logic          din;
        logic          press_l, active_l;

        assign din = sync2_reg[gi];

        always_ff @(posedge clock) begin
            if (!reset) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
            end else begin
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
            end
        end

        always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            case (state_reg)
                IDLE: if (din) begin
                    state_next = ARM_PRESS;
                    cnt_next   = CW'(1);
                end
                ARM_PRESS: begin
                    if (!din) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt_reg >= CNT_LAST) begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = sat_inc(cnt_reg);
                    end
                end
                HELD: if (!din) begin
                    state_next = ARM_RELEASE;
                    cnt_next   = CW'(1);
                end
                ARM_RELEASE: begin
                    if (din) begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end else if (cnt_reg >= CNT_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = sat_inc(cnt_reg);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

        always_comb begin
            press_l  = (state_reg == ARM_PRESS) && din && (cnt_reg >= CNT_LAST);
            active_l = (state_reg == HELD) || (state_reg == ARM_RELEASE);
        end

        assign press_evt[gi]  = press_l;
        assign btn_active[gi] = active_l;
    end

    // Two-stage hold keeps cpu_reset up through the first cycle after reset releases.
    always_ff @(posedge clock) begin
        if (!reset) rst_hold_reg <= 2'b11;
        else        rst_hold_reg <= {rst_hold_reg[0], 1'b0};
    end

    assign cpu_reset = rst_hold_reg[1] | btn_active[1];

`ifdef STEP_CONTROLLER_AUTORUN_EN
    localparam int RW = (RUN_PERIOD < 2) ? 1 : $clog2(RUN_PERIOD);
    logic [RW-1:0] run_cnt_reg;

    assign running    = sync2_reg[2] & ~cpu_reset;
    assign auto_evt   = running && (run_cnt_reg == RW'(RUN_PERIOD - 1));
    assign manual_evt = press_evt[0] & ~running;

    always_ff @(posedge clock) begin
        if (!reset || !running) run_cnt_reg <= '0;
        else if (auto_evt)      run_cnt_reg <= '0;
        else                    run_cnt_reg <= run_cnt_reg + 1'b1;
    end
`else
    assign running    = 1'b0;
    assign auto_evt   = 1'b0;
    assign manual_evt = press_evt[0];
`endif

    // Manual and auto events merge into a single strobe; a gated strobe is dropped.
    always_ff @(posedge clock) begin
        if (!reset) pulse_reg <= 1'b0;
        else        pulse_reg <= manual_evt | auto_evt;
    end

    assign step_pulse = pulse_reg & ~cpu_reset;

    always_ff @(posedge clock) begin
        if (!reset)          step_count_reg <= '0;
        else if (cpu_reset)  step_count_reg <= '0;
        else if (step_pulse) step_count_reg <= step_count_reg + 16'd1;
    end

    assign step_count = step_count_reg;

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable synchronized samples required to accept a button level change.
REQ-002 The block SHALL have parameter RUN_PERIOD, default 25000000: clock cycles between auto-run step pulses; values below 2 are illegal.
REQ-003 The block SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset of this block.
REQ-005 The block SHALL have port step_button  input  1  raw asynchronous step push-button, high = pressed.
REQ-006 The block SHALL have port reset_button  input  1  raw asynchronous CPU-reset push-button, high = pressed.
REQ-007 The block SHALL have port run_switch  input  1  raw asynchronous slide switch, high = auto-run requested.
REQ-008 The block SHALL have port step_pulse  output  1  one-cycle CPU advance strobe, active-high.
REQ-009 The block SHALL have port cpu_reset  output  1  active-high reset level driven to Control/DataPath.
REQ-010 The block SHALL have port step_count  output  16  number of step pulses since the last cpu_reset.
REQ-011 The block SHALL have port running  output  1  high while auto-run mode is active.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each button SHALL have an independent debouncer FSM with states IDLE, ARM_PRESS, HELD, ARM_RELEASE.
REQ-014 IDLE->ARM_PRESS on synchronized high; ARM_PRESS->IDLE on any low sample (counter cleared); ARM_PRESS->HELD after DEBOUNCE_CYCLES consecutive high samples.
REQ-015 HELD->ARM_RELEASE on synchronized low; ARM_RELEASE->HELD on any high sample; ARM_RELEASE->IDLE after DEBOUNCE_CYCLES consecutive low samples.
REQ-016 Debounce counters SHALL saturate; they SHALL NOT wrap.
REQ-017 step_pulse SHALL be high for exactly one cycle on the step debouncer's ARM_PRESS->HELD transition, i.e. DEBOUNCE_CYCLES+2 cycles after step_button is first sampled high and held.
REQ-018 A held step button SHALL produce exactly one pulse regardless of hold duration.
REQ-019 cpu_reset SHALL be high while the reset debouncer is in HELD or ARM_RELEASE.
REQ-020 step_pulse SHALL be forced low in any cycle where cpu_reset is high; a step transition in that cycle is discarded, not deferred.
REQ-021 step_count SHALL increment by 1 in the cycle after each step_pulse, wrapping 16'hFFFF->16'h0000.
REQ-022 step_count SHALL be held at 0 while cpu_reset is high.
REQ-023 When manual and auto-run pulses coincide, only one step_pulse SHALL be issued.

Reset
REQ-024 With reset low at a clock edge, all FSMs SHALL enter IDLE and all counters and synchronizers SHALL clear.
REQ-025 Reset values SHALL be: step_pulse 0, cpu_reset 1, step_count 0, running 0.
REQ-026 cpu_reset SHALL remain 1 for the first cycle after reset deasserts, then follow REQ-019.
REQ-027 Reset asserted mid-debounce or mid-run SHALL abort the operation with no step_pulse emitted.

Configuration
REQ-028 The macro STEP_CONTROLLER_AUTORUN_EN SHALL control the auto-run feature.
REQ-029 With the macro defined: running = synchronized run_switch AND NOT cpu_reset; while running, a period counter SHALL emit step_pulse every RUN_PERIOD cycles, first pulse RUN_PERIOD cycles after running rises; the counter SHALL clear when running falls; the step button SHALL be ignored while running.
REQ-030 With the macro undefined: run_switch is unused, running is constant 0, no period counter is synthesized, and only manual steps occur.

Verification (DEBOUNCE_CYCLES=4, RUN_PERIOD=8)
REQ-031 step_button high for 20 cycles from cycle 0 -> single step_pulse at cycle 6; step_count=1 at cycle 7.
REQ-032 step_button toggling every 2 cycles for 20 cycles -> no step_pulse; step_count stays 0.
REQ-033 reset_button held 10 cycles while step_count=5 -> cpu_reset high from cycle 6; step_count=0; a step press in that window yields no pulse.
REQ-034 step_count preloaded to 16'hFFFF by 65535 pulses, then one more press -> step_count=16'h0000.
REQ-035 Macro defined, run_switch high 40 cycles -> running high from cycle 2; step_pulse at cycles 10,18,26,34,42; macro undefined -> no pulses.
REQ-036 reset low during ARM_PRESS at count 3 -> no step_pulse; outputs equal REQ-025 values.
